// File: rtl/rgb_seq_pkg.sv
// Shared types and the fixed six-colour palette for the RGB fade sequencer.
// Levels are full-scale per channel; LEVEL_BITS sets the channel width of rgb_t.
package rgb_seq_pkg;

    localparam int LEVEL_BITS = 4;
    localparam int NUM_COLORS = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_FADE     = 2'd2,
        ST_OVERRIDE = 2'd3
    } state_t;

    typedef struct packed {
        logic [LEVEL_BITS-1:0] r;
        logic [LEVEL_BITS-1:0] g;
        logic [LEVEL_BITS-1:0] b;
    } rgb_t;

    localparam logic [LEVEL_BITS-1:0] FULL = {LEVEL_BITS{1'b1}};
    localparam logic [LEVEL_BITS-1:0] ZERO = {LEVEL_BITS{1'b0}};

    // red, yellow, green, cyan, blue, magenta
    function automatic rgb_t palette_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: FULL, g: ZERO, b: ZERO};
            3'd1:    c = '{r: FULL, g: FULL, b: ZERO};
            3'd2:    c = '{r: ZERO, g: FULL, b: ZERO};
            3'd3:    c = '{r: ZERO, g: FULL, b: FULL};
            3'd4:    c = '{r: ZERO, g: ZERO, b: FULL};
            3'd5:    c = '{r: FULL, g: ZERO, b: FULL};
            default: c = '{r: ZERO, g: ZERO, b: ZERO};
        endcase
        return c;
    endfunction

    function automatic logic [2:0] next_color(input logic [2:0] idx);
        return (idx == 3'(NUM_COLORS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_lerp.sv
// Combinational linear interpolation src -> dst at step k of FADE_STEPS,
// one signed multiply-and-floor-shift per channel.
module rgb_lerp
    import rgb_seq_pkg::*;
#(
    parameter int FADE_STEPS = 16,
    localparam int SHIFT = $clog2(FADE_STEPS),
    localparam int KW = SHIFT + 1
) (
    input  rgb_t            src,
    input  rgb_t            dst,
    input  logic [KW-1:0]   k,
    output rgb_t            mixed
);

    localparam int DW = LEVEL_BITS + 1;
    localparam int PW = DW + KW + 1;

    logic [LEVEL_BITS-1:0] src_ch [3];
    logic [LEVEL_BITS-1:0] dst_ch [3];
    logic [LEVEL_BITS-1:0] mix_ch [3];

    assign src_ch[0] = src.r;
    assign src_ch[1] = src.g;
    assign src_ch[2] = src.b;
    assign dst_ch[0] = dst.r;
    assign dst_ch[1] = dst.g;
    assign dst_ch[2] = dst.b;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic signed [DW-1:0] diff;
            logic signed [PW-1:0] prod;

            assign diff = $signed({1'b0, dst_ch[gi]}) - $signed({1'b0, src_ch[gi]});
            assign prod = PW'(diff) * PW'($signed({1'b0, k}));
            // Arithmetic shift floors negative steps; the sum never leaves 0..full.
            assign mix_ch[gi] = LEVEL_BITS'(PW'($signed({1'b0, src_ch[gi]})) + (prod >>> SHIFT));
        end
    endgenerate

    assign mixed = '{r: mix_ch[0], g: mix_ch[1], b: mix_ch[2]};

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps the RGB PWM intensities through the palette: hold, fade to the next
// colour, wrap; a level-sensitive override and a pause input sit on top.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int TICK_DIV   = 33333,
    parameter int PWM_BITS   = 4,
    parameter int HOLD_STEPS = 60,
    parameter int FADE_STEPS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  ovr_valid,
    input  logic [3*PWM_BITS-1:0] ovr_rgb,
    output logic [PWM_BITS-1:0]   r_level,
    output logic [PWM_BITS-1:0]   g_level,
    output logic [PWM_BITS-1:0]   b_level,
    output logic [2:0]            color_idx,
    output logic                  fading,
    output logic                  step_tick
);

    localparam int PSW = $clog2(TICK_DIV);
    localparam int HW  = $clog2(HOLD_STEPS + 1);
    localparam int KW  = $clog2(FADE_STEPS) + 1;

    state_t          state_reg;
    logic [PSW-1:0]  presc_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [KW-1:0]   k_reg;
    logic [2:0]      color_idx_reg;
    rgb_t            levels_reg;
    logic            fading_reg;
    logic            step_tick_reg;

    logic            counting;
    logic            wrap;
    logic [KW-1:0]   k_next;
    logic [HW-1:0]   hold_next;
    rgb_t            src_rgb;
    rgb_t            dst_rgb;
    rgb_t            fade_rgb;

    assign counting  = (state_reg == ST_HOLD || state_reg == ST_FADE) && !pause;
    assign wrap      = counting && (presc_reg == PSW'(TICK_DIV - 1));
    assign k_next    = k_reg + KW'(1);
    assign hold_next = hold_cnt_reg + HW'(1);
    assign src_rgb   = palette_color(color_idx_reg);
    assign dst_rgb   = palette_color(next_color(color_idx_reg));

    rgb_lerp #(.FADE_STEPS(FADE_STEPS)) u_lerp (
        .src   (src_rgb),
        .dst   (dst_rgb),
        .k     (k_next),
        .mixed (fade_rgb)
    );

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_reg     <= ST_IDLE;
            presc_reg     <= '0;
            hold_cnt_reg  <= '0;
            k_reg         <= '0;
            color_idx_reg <= '0;
            levels_reg    <= '0;
            fading_reg    <= 1'b0;
            step_tick_reg <= 1'b0;
        end else begin
            step_tick_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    state_reg     <= ST_HOLD;
                    color_idx_reg <= '0;
                    levels_reg    <= palette_color(3'd0);
                    presc_reg     <= '0;
                    hold_cnt_reg  <= '0;
                    k_reg         <= '0;
                end
                ST_HOLD, ST_FADE: begin
                    if (ovr_valid) begin
                        state_reg  <= ST_OVERRIDE;
                        levels_reg <= rgb_t'(ovr_rgb);
                        fading_reg <= 1'b0;
                    end else if (wrap) begin
                        step_tick_reg <= 1'b1;
                        presc_reg     <= '0;
                        if (state_reg == ST_HOLD) begin
                            if (hold_next == HW'(HOLD_STEPS)) begin
                                state_reg    <= ST_FADE;
                                hold_cnt_reg <= '0;
                                k_reg        <= '0;
                                fading_reg   <= 1'b1;
                            end else begin
                                hold_cnt_reg <= hold_next;
                            end
                        end else if (k_next == KW'(FADE_STEPS)) begin
                            state_reg     <= ST_HOLD;
                            levels_reg    <= dst_rgb;
                            color_idx_reg <= next_color(color_idx_reg);
                            fading_reg    <= 1'b0;
                            k_reg         <= '0;
                            hold_cnt_reg  <= '0;
                        end else begin
                            levels_reg <= fade_rgb;
                            k_reg      <= k_next;
                        end
                    end else if (!pause) begin
                        presc_reg <= presc_reg + PSW'(1);
                    end
                end
                default: begin
                    if (ovr_valid) begin
                        levels_reg <= rgb_t'(ovr_rgb);
                    end else begin
                        // Leaving override abandons any fade and restarts the hold.
                        state_reg    <= ST_HOLD;
                        levels_reg   <= src_rgb;
                        presc_reg    <= '0;
                        hold_cnt_reg <= '0;
                        k_reg        <= '0;
                    end
                end
            endcase
        end
    end

    assign r_level   = levels_reg.r;
    assign g_level   = levels_reg.g;
    assign b_level   = levels_reg.b;
    assign color_idx = color_idx_reg;
    assign fading    = fading_reg;
    assign step_tick = step_tick_reg;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with TICK_DIV=4, HOLD_STEPS=2, FADE_STEPS=4.
module tb_rgb_fade_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        pause;
    logic        ovr_valid;
    logic [11:0] ovr_rgb;
    logic [3:0]  r_level;
    logic [3:0]  g_level;
    logic [3:0]  b_level;
    logic [2:0]  color_idx;
    logic        fading;
    logic        step_tick;

    int check_count = 0;
    int error_count = 0;

    rgb_fade_sequencer #(
        .TICK_DIV   (4),
        .PWM_BITS   (4),
        .HOLD_STEPS (2),
        .FADE_STEPS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pause     (pause),
        .ovr_valid (ovr_valid),
        .ovr_rgb   (ovr_rgb),
        .r_level   (r_level),
        .g_level   (g_level),
        .b_level   (b_level),
        .color_idx (color_idx),
        .fading    (fading),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        check_count++;
        if (obs != exp) begin
            error_count++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rgb();
        return int'({r_level, g_level, b_level});
    endfunction

    // Returns the number of cycles until the next step_tick, sampled on negedge.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_tick && n < 40);
        if (!step_tick) check("tick_timeout", n, -1);
    endtask

    task automatic run_hold();
        int n;
        wait_tick(n);
        check("hold_gap", n, 4);
        check("hold1_fading", int'(fading), 0);
        wait_tick(n);
        check("hold_gap", n, 4);
        check("hold2_fading", int'(fading), 1);
        $display("hold done idx=%0d rgb=%03h", color_idx, rgb());
    endtask

    int n;
    int exp_up[4] = '{3, 7, 11, 15};
    int exp_dn[4] = '{11, 7, 3, 0};
    int end_rgb[3] = '{12'h0FF, 12'h00F, 12'hF0F};
    int ticks_seen;
    int rgb_moves;

    initial begin
        reset = 1'b1; enable = 1'b0; pause = 1'b0; ovr_valid = 1'b0; ovr_rgb = '0;

        // 1: reset and enable
        repeat (3) begin
            @(negedge clk);
            check("reset_rgb", rgb(), 0);
        end
        check("reset_idx", int'(color_idx), 0);
        check("reset_fading", int'(fading), 0);
        check("reset_tick", int'(step_tick), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_rgb", rgb(), 0);
        enable = 1'b1;
        @(negedge clk);
        check("enable_rgb", rgb(), 12'hF00);
        check("enable_idx", int'(color_idx), 0);
        $display("enable rgb=%03h idx=%0d", rgb(), color_idx);

        // 2: red -> yellow
        run_hold();
        check("hold_rgb", rgb(), 12'hF00);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            check("fade_gap", n, 4);
            check("ry_g", int'(g_level), exp_up[i]);
            check("ry_r", int'(r_level), 15);
            $display("fade red->yellow k=%0d rgb=%03h", i + 1, rgb());
        end
        check("ry_idx", int'(color_idx), 1);
        check("ry_fading", int'(fading), 0);

        // 3: yellow -> green
        run_hold();
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            check("yg_r", int'(r_level), exp_dn[i]);
            check("yg_g", int'(g_level), 15);
            $display("fade yellow->green k=%0d rgb=%03h", i + 1, rgb());
        end
        check("yg_idx", int'(color_idx), 2);

        // 4: through to magenta and wrap
        for (int c = 2; c < 5; c++) begin
            run_hold();
            repeat (4) wait_tick(n);
            check("cycle_idx", int'(color_idx), c + 1);
            check("cycle_rgb", rgb(), end_rgb[c-2]);
            $display("reached idx=%0d rgb=%03h", color_idx, rgb());
        end
        run_hold();
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            check("mr_b", int'(b_level), exp_dn[i]);
            check("mr_r", int'(r_level), 15);
            $display("fade magenta->red k=%0d rgb=%03h", i + 1, rgb());
        end
        check("wrap_idx", int'(color_idx), 0);
        wait_tick(n);
        check("wrap_hold_rgb", rgb(), 12'hF00);
        check("wrap_hold_fading", int'(fading), 0);

        // 5: override at k=2
        wait_tick(n);
        check("pre_ovr_fading", int'(fading), 1);
        wait_tick(n);
        wait_tick(n);
        check("pre_ovr_rgb", rgb(), 12'hF70);
        ovr_valid = 1'b1; ovr_rgb = 12'h5A1;
        @(negedge clk);
        check("ovr_rgb", rgb(), 12'h5A1);
        check("ovr_fading", int'(fading), 0);
        $display("override rgb=%03h", rgb());
        ovr_rgb = 12'h009;
        @(negedge clk);
        check("ovr_track", rgb(), 12'h009);
        check("ovr_idx", int'(color_idx), 0);
        $display("override rgb=%03h", rgb());
        ovr_valid = 1'b0;
        @(negedge clk);
        check("release_rgb", rgb(), 12'hF00);
        check("release_fading", int'(fading), 0);
        $display("release rgb=%03h", rgb());
        run_hold();

        // 6: pause mid-fade, then disable
        wait_tick(n);
        check("pre_pause_rgb", rgb(), 12'hF30);
        @(negedge clk);
        @(negedge clk);
        pause = 1'b1;
        ticks_seen = 0;
        rgb_moves = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_tick) ticks_seen++;
            if (rgb() != 12'hF30) rgb_moves++;
        end
        check("pause_ticks", ticks_seen, 0);
        check("pause_rgb_moves", rgb_moves, 0);
        $display("pause held rgb=%03h", rgb());
        pause = 1'b0;
        wait_tick(n);
        check("resume_gap", n, 2);
        check("resume_rgb", rgb(), 12'hF70);
        wait_tick(n);
        check("resume_gap2", n, 4);
        check("resume_rgb2", rgb(), 12'hFB0);
        $display("resume rgb=%03h", rgb());
        enable = 1'b0;
        @(negedge clk);
        check("disable_rgb", rgb(), 0);
        check("disable_idx", int'(color_idx), 0);
        check("disable_fading", int'(fading), 0);
        $display("disable rgb=%03h idx=%0d", rgb(), color_idx);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
